tt_sel_ctrl: RTL and testbench
==============================

// Module: tt_sel_ctrl
// PURPOSE
//   Design-select sequencer that sits in the controller between the control-high pads and the spine.
//   Synchronises ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
//   Counts sel_inc pulses into a user-module address, then runs a settle window before driving the
//   row muxers with the address and enable. The enable is never asserted while the address is changing.
// PARAMETERS
//   N_UM        384  number of user-module slots; address wraps at N_UM
//   ADDR_W      10   width of address outputs; must satisfy 2**ADDR_W >= N_UM
//   SYNC_STAGES 2    flops per pad synchroniser (>=2)
//   SETTLE_CYC  4    cycles spine_addr is held before spine_ena rises (>=1)
// PORTS
//   clk             in   1       design clock
//   rst             in   1       synchronous reset, active-high
//   ctrl_sel_rst_n  in   1       async pad; low clears selection
//   ctrl_sel_inc    in   1       async pad; each rising edge advances selection
//   ctrl_ena        in   1       async pad; high requests the selected design be enabled
//   sel_addr        out  ADDR_W  live selection counter
//   spine_addr      out  ADDR_W  address broadcast to row muxers; frozen outside IDLE
//   spine_ena       out  1       enable of the addressed user module
//   sel_busy        out  1       high when state != IDLE
//   inc_wrap        out  1       1-cycle pulse when the counter wraps N_UM-1 -> 0
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     - sel_addr=0, spine_addr=0, spine_ena=0, sel_busy=0, inc_wrap=0, state=IDLE.
//     - Sync chains clear to 0, so sel_rst is treated as asserted until the pad reads high.
//   Sync: each pad goes through SYNC_STAGES flops; s_* denotes the last stage.
//     inc_edge = s_inc & ~s_inc_q, where s_inc_q is one extra flop.
//     Pad-to-effect latency: SYNC_STAGES+1 edges.
//   Priority per cycle (highest first): rst > ~s_sel_rst_n > ~s_ena > inc_edge.
//   ~s_sel_rst_n, in any state:
//     - sel_addr=0, spine_addr=0, spine_ena=0, state -> IDLE next edge.
//     - inc_edge is discarded.
//   FSM (states IDLE, SETTLE, ACTIVE):
//     - IDLE:
//         - inc_edge: sel_addr <= (sel_addr==N_UM-1) ? 0 : sel_addr+1; on wrap, inc_wrap=1 for that cycle.
//         - s_ena=1: spine_addr <= sel_addr, settle counter <= SETTLE_CYC-1, state -> SETTLE.
//         - If inc_edge and s_ena=1 occur in the same cycle: the increment wins, and SETTLE entry
//           waits one cycle so the latched address includes the increment.
//     - SETTLE:
//         - spine_ena=0, spine_addr stable.
//         - Counter decrements; at 0 -> ACTIVE.
//         - s_ena=0 -> IDLE; spine_ena is never asserted.
//     - ACTIVE:
//         - spine_ena=1 (registered; first high cycle = first ACTIVE cycle).
//         - s_ena=0: spine_ena=0 on the next edge, state -> IDLE; spine_addr is retained.
//   inc_edge in SETTLE/ACTIVE: ignored, sel_addr frozen. inc held high across the return to IDLE
//     produces no increment; a new rising edge is required.
//   Timing: spine_ena rises exactly SETTLE_CYC+1 edges after s_ena is first seen high in IDLE.
//   spine_addr only changes on IDLE->SETTLE or on sel reset. No output is combinational from a pad.
// TESTING
//   1. rst, pads sel_rst_n=1, ena=0, 5 inc pulses -> sel_addr=5, spine_ena=0, inc_wrap never set.
//   2. sel_addr=5, raise ena -> spine_addr=5 at SETTLE entry; spine_ena=1 exactly SETTLE_CYC+1 edges
//      after s_ena; sel_busy=1 from SETTLE entry.
//   3. ACTIVE at addr 5, 3 inc pulses -> sel_addr stays 5; drop ena -> spine_ena=0 next edge;
//      spine_addr stays 5.
//   4. sel_addr=383 (N_UM=384), 1 inc -> sel_addr=0, inc_wrap high exactly 1 cycle.
//   5. ena drops after 2 SETTLE cycles -> IDLE, spine_ena never 1. Then assert sel_rst_n=0 in ACTIVE
//      -> all outputs 0, state IDLE.
//   6. inc edge and ena rise in the same synced cycle at addr 7 -> spine_addr=8. Then rst mid-ACTIVE
//      -> every output equals its reset value the next edge.

Source files
------------

// File: rtl/tt_sel_ctrl.sv
// Design-select sequencer: synchronises the control pads, counts select pulses into a
// user-module address and hands it to the spine only after a settle window.
module tt_sel_ctrl #(
  parameter int N_UM        = 384,
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_sel_rst_n,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [ADDR_W-1:0] spine_addr,
  output logic              spine_ena,
  output logic              sel_busy,
  output logic              inc_wrap
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_UM - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [SYNC_STAGES-1:0] rstn_sync_p0;
  logic [SYNC_STAGES-1:0] inc_sync_p0;
  logic [SYNC_STAGES-1:0] ena_sync_p0;
  logic                   inc_q_p1;
  logic                   s_sel_rst_n;
  logic                   s_inc;
  logic                   s_ena;
  logic                   inc_edge;
  logic [1:0]             state;
  logic [CNT_W-1:0]       settle_cnt;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_ONE;
  endfunction

  // Pad synchronisers; clearing to 0 keeps the selection held in reset until the pad reads high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstn_sync_p0 <= '0;
      inc_sync_p0  <= '0;
      ena_sync_p0  <= '0;
      inc_q_p1     <= 1'b0;
    end else begin
      rstn_sync_p0 <= {rstn_sync_p0[SYNC_STAGES-2:0], ctrl_sel_rst_n};
      inc_sync_p0  <= {inc_sync_p0[SYNC_STAGES-2:0], ctrl_sel_inc};
      ena_sync_p0  <= {ena_sync_p0[SYNC_STAGES-2:0], ctrl_ena};
      inc_q_p1     <= s_inc;
    end
  end

  assign s_sel_rst_n = rstn_sync_p0[SYNC_STAGES-1];
  assign s_inc       = inc_sync_p0[SYNC_STAGES-1];
  assign s_ena       = ena_sync_p0[SYNC_STAGES-1];
  assign inc_edge    = s_inc & ~inc_q_p1;

  // Sequencer; an increment in IDLE defers SETTLE entry so the latched address includes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      sel_addr   <= '0;
      spine_addr <= '0;
      spine_ena  <= 1'b0;
      inc_wrap   <= 1'b0;
    end else begin
      inc_wrap <= 1'b0;
      if (!s_sel_rst_n) begin
        state      <= ST_IDLE;
        sel_addr   <= '0;
        spine_addr <= '0;
        spine_ena  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (inc_edge) begin
              sel_addr <= next_addr(sel_addr);
              inc_wrap <= (sel_addr == ADDR_LAST);
            end else if (s_ena) begin
              spine_addr <= sel_addr;
              settle_cnt <= CNT_INIT;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (!s_ena) begin
              state <= ST_IDLE;
            end else if (settle_cnt == '0) begin
              state     <= ST_ACTIVE;
              spine_ena <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            if (!s_ena) begin
              state     <= ST_IDLE;
              spine_ena <= 1'b0;
            end
          end
          default: begin
            state     <= ST_IDLE;
            spine_ena <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Bench for tt_sel_ctrl: directed scenarios plus random pad activity, compared every cycle
// against a behavioural model of the selection sequencer.
module tb_tt_sel_ctrl;
  localparam int N_UM        = 384;
  localparam int ADDR_W      = 10;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_CYC  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] spine_addr;
  logic              spine_ena;
  logic              sel_busy;
  logic              inc_wrap;

  tt_sel_ctrl #(
    .N_UM(N_UM), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .sel_addr(sel_addr), .spine_addr(spine_addr),
    .spine_ena(spine_ena), .sel_busy(sel_busy), .inc_wrap(inc_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int ena_cnt = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: pads seen after a fixed delay; m_left = -1 idle, >0 settling, 0 enabled.
  int m_sel, m_spine, m_left;
  bit m_ena, m_wrap, m_inc_prev;
  bit q_rstn[$];
  bit q_inc[$];
  bit q_ena[$];

  task automatic model_reset();
    m_sel = 0; m_spine = 0; m_left = -1; m_ena = 0; m_wrap = 0; m_inc_prev = 0;
    q_rstn.delete(); q_inc.delete(); q_ena.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      q_rstn.push_back(1'b0); q_inc.push_back(1'b0); q_ena.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit s_rstn, s_inc, s_ena, inc_ev;
    if (rst) begin
      model_reset();
      return;
    end
    s_rstn = q_rstn[0];
    s_inc  = q_inc[0];
    s_ena  = q_ena[0];
    inc_ev = s_inc && !m_inc_prev;
    m_wrap = 0;
    if (!s_rstn) begin
      m_sel = 0; m_spine = 0; m_ena = 0; m_left = -1;
    end else if (m_left < 0) begin
      if (inc_ev) begin
        m_sel  = (m_sel + 1) % N_UM;
        m_wrap = (m_sel == 0);
      end else if (s_ena) begin
        m_spine = m_sel;
        m_left  = SETTLE_CYC;
      end
    end else if (!s_ena) begin
      m_left = -1;
      m_ena  = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ena = 1;
    end
    m_inc_prev = s_inc;
    void'(q_rstn.pop_front()); q_rstn.push_back(ctrl_sel_rst_n);
    void'(q_inc.pop_front());  q_inc.push_back(ctrl_sel_inc);
    void'(q_ena.pop_front());  q_ena.push_back(ctrl_ena);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_sel_addr", int'(sel_addr), m_sel);
    chk("m_spine_addr", int'(spine_addr), m_spine);
    chk("m_spine_ena", int'(spine_ena), int'(m_ena));
    chk("m_sel_busy", int'(sel_busy), (m_left >= 0) ? 1 : 0);
    chk("m_inc_wrap", int'(inc_wrap), int'(m_wrap));
    if (inc_wrap) wrap_cnt++;
    if (spine_ena) ena_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_inc();
    ctrl_sel_inc = 1'b1;
    tick();
    ctrl_sel_inc = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, int'(sel_addr), 0);
    chk({tag, "_spine"}, int'(spine_addr), 0);
    chk({tag, "_ena"}, int'(spine_ena), 0);
    chk({tag, "_busy"}, int'(sel_busy), 0);
    chk({tag, "_wrap"}, int'(inc_wrap), 0);
  endtask

  initial begin
    int first_busy, first_ena;
    bit found;
    rst = 1'b1; ctrl_sel_rst_n = 1'b1; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
    model_reset();
    ticks(3);
    chk_all_zero("reset");

    // 1: five increments with enable low
    rst = 1'b0;
    ticks(SYNC_STAGES + 1);
    wrap_cnt = 0;
    repeat (5) pulse_inc();
    ticks(4);
    chk("t1_sel", int'(sel_addr), 5);
    chk("t1_ena", int'(spine_ena), 0);
    chk("t1_wrap", wrap_cnt, 0);

    // 2: enable at address 5, measure settle timing from the pad edge
    ctrl_ena = 1'b1;
    first_busy = -1; first_ena = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel_busy && first_busy < 0) first_busy = i;
      if (spine_ena && first_ena < 0) first_ena = i;
      if (i == SYNC_STAGES + 1) chk("t2_spine_addr", int'(spine_addr), 5);
    end
    chk("t2_busy_at", first_busy, SYNC_STAGES + 1);
    chk("t2_ena_at", first_ena, SYNC_STAGES + SETTLE_CYC + 1);

    // 3: increments ignored while active; inc held high across the return to idle
    repeat (3) pulse_inc();
    ticks(3);
    chk("t3_sel", int'(sel_addr), 5);
    chk("t3_active", int'(spine_ena), 1);
    ctrl_sel_inc = 1'b1;
    ticks(3);
    ctrl_ena = 1'b0;
    ticks(SYNC_STAGES);
    chk("t3_ena_hold", int'(spine_ena), 1);
    tick();
    chk("t3_ena_drop", int'(spine_ena), 0);
    chk("t3_spine", int'(spine_addr), 5);
    chk("t3_busy", int'(sel_busy), 0);
    ticks(5);
    chk("t3_no_incr", int'(sel_addr), 5);
    ctrl_sel_inc = 1'b0;
    ticks(3);

    // 4: wrap from N_UM-1 to 0
    repeat (N_UM - 1 - 5) pulse_inc();
    ticks(4);
    chk("t4_pre", int'(sel_addr), N_UM - 1);
    wrap_cnt = 0;
    pulse_inc();
    ticks(4);
    chk("t4_sel", int'(sel_addr), 0);
    chk("t4_wrap_cnt", wrap_cnt, 1);

    // 5: abort during settle, then selection reset while active
    repeat (3) pulse_inc();
    ticks(4);
    ena_cnt = 0;
    ctrl_ena = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (sel_busy) found = 1;
    end
    chk("t5_settle_entry", int'(found), 1);
    ctrl_ena = 1'b0;
    ticks(10);
    chk("t5_ena_never", ena_cnt, 0);
    chk("t5_busy", int'(sel_busy), 0);
    ctrl_ena = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (spine_ena) found = 1;
    end
    chk("t5_active", int'(found), 1);
    chk("t5_spine", int'(spine_addr), 3);
    ctrl_sel_rst_n = 1'b0;
    ticks(SYNC_STAGES + 1);
    chk_all_zero("t5_selrst");
    ctrl_ena = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ticks(SYNC_STAGES + 2);

    // 6: increment and enable in the same synced cycle, then rst while active
    repeat (7) pulse_inc();
    ticks(4);
    chk("t6_pre", int'(sel_addr), 7);
    ctrl_sel_inc = 1'b1;
    ctrl_ena = 1'b1;
    tick();
    ctrl_sel_inc = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (spine_ena) found = 1;
    end
    chk("t6_active", int'(found), 1);
    chk("t6_spine", int'(spine_addr), 8);
    chk("t6_sel", int'(sel_addr), 8);
    rst = 1'b1;
    tick();
    chk_all_zero("t6_rst");
    ctrl_ena = 1'b0;
    rst = 1'b0;
    ticks(SYNC_STAGES + 2);

    // Random pad activity
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
      if ($urandom_range(0, 15) == 0) ctrl_ena = ~ctrl_ena;
      ctrl_sel_rst_n = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
